// File: rtl/charge_session_ctrl_if.sv
// Keypad-scanner key bus and session status toward the charging output/display block.
interface charge_session_ctrl_if;
   logic        key_valid;
   logic [4:0]  key_num;
   logic        key_start;
   logic        key_clear;
   logic        key_enter;
   logic [1:0]  state;
   logic [3:0]  amt_tens;
   logic [3:0]  amt_ones;
   logic [15:0] rem_sec;
   logic        charging;
   logic        done;

   modport master (
      output key_valid, key_num, key_start, key_clear, key_enter,
      input  state, amt_tens, amt_ones, rem_sec, charging, done
   );

   modport slave (
      input  key_valid, key_num, key_start, key_clear, key_enter,
      output state, amt_tens, amt_ones, rem_sec, charging, done
   );
endinterface

// File: rtl/charge_session_ctrl.sv
// Charging session sequencer: idle, 2-digit amount entry, timed countdown, done.
// Optional macro AUTO_TIMEOUT_EN aborts a stalled amount entry after IDLE_TIMEOUT seconds.
module charge_session_ctrl #(
   parameter int TICK_DIV     = 1000,
   parameter int SEC_PER_UNIT = 2
`ifdef AUTO_TIMEOUT_EN
   , parameter int IDLE_TIMEOUT = 10
`endif
) (
   input  logic                CLK,
   input  logic                RST_N,
   charge_session_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ENTRY  = 2'd1,
      S_CHARGE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [15:0]     SPU     = 16'(SEC_PER_UNIT);

   state_t        st, st_n;
   logic [3:0]    tens, tens_n;
   logic [3:0]    ones, ones_n;
   logic [1:0]    cnt, cnt_n;
   logic [15:0]   rem, rem_n;
   logic [PW-1:0] pre, pre_n;
   logic          sync1, sync2, sync3, key_evt;
   logic          do_clear, do_enter, do_start, do_digit;
   logic          tick;
   logic [15:0]   amt_bin;

`ifdef AUTO_TIMEOUT_EN
   localparam int            TW     = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(IDLE_TIMEOUT - 1);
   logic [TW-1:0] to_cnt, to_n;
`endif

   // key_evt is registered so the key takes effect on the 4th edge after key_valid is seen high
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync3   <= 1'b0;
         key_evt <= 1'b0;
      end else begin
         sync1   <= bus.key_valid;
         sync2   <= sync1;
         sync3   <= sync2;
         key_evt <= sync2 & ~sync3;
      end
   end

   assign do_clear = key_evt & bus.key_clear;
   assign do_enter = key_evt & ~bus.key_clear & bus.key_enter;
   assign do_start = key_evt & ~bus.key_clear & ~bus.key_enter & bus.key_start;
   assign do_digit = key_evt & ~bus.key_clear & ~bus.key_enter & ~bus.key_start
                     & (bus.key_num <= 5'd9);

   assign tick    = (pre == PRE_MAX);
   assign amt_bin = {12'd0, tens} * 16'd10 + {12'd0, ones};

   always_comb begin
      st_n   = st;
      tens_n = tens;
      ones_n = ones;
      cnt_n  = cnt;
      rem_n  = rem;
      pre_n  = pre;
`ifdef AUTO_TIMEOUT_EN
      to_n   = to_cnt;
`endif
      unique case (st)
         S_IDLE: begin
            if (do_start) begin
               st_n   = S_ENTRY;
               tens_n = 4'd0;
               ones_n = 4'd0;
               cnt_n  = 2'd0;
               pre_n  = '0;
            end
         end
         S_ENTRY: begin
`ifdef AUTO_TIMEOUT_EN
            // Prescaler doubles as the seconds base for the entry timeout
            if (key_evt) begin
               pre_n = '0;
               to_n  = '0;
            end else if (tick) begin
               pre_n = '0;
               if (to_cnt == TO_MAX) begin
                  st_n   = S_IDLE;
                  tens_n = 4'd0;
                  ones_n = 4'd0;
                  cnt_n  = 2'd0;
                  to_n   = '0;
               end else begin
                  to_n = to_cnt + TW'(1);
               end
            end else begin
               pre_n = pre + PW'(1);
            end
`endif
            if (do_clear) begin
               tens_n = 4'd0;
               ones_n = 4'd0;
               cnt_n  = 2'd0;
            end else if (do_enter && (amt_bin != 16'd0)) begin
               rem_n = amt_bin * SPU;
               pre_n = '0;
               st_n  = S_CHARGE;
            end else if (do_digit && (cnt != 2'd2)) begin
               tens_n = ones;
               ones_n = bus.key_num[3:0];
               cnt_n  = cnt + 2'd1;
            end
         end
         S_CHARGE: begin
            if (tick) begin
               pre_n = '0;
               rem_n = rem - 16'd1;
               if (rem == 16'd1) begin
                  st_n = S_DONE;
               end
            end else begin
               pre_n = pre + PW'(1);
            end
            // An abort wins over a final tick landing on the same edge
            if (do_clear) begin
               st_n   = S_IDLE;
               rem_n  = 16'd0;
               tens_n = 4'd0;
               ones_n = 4'd0;
               cnt_n  = 2'd0;
               pre_n  = '0;
            end
         end
         S_DONE: begin
            if (do_clear) begin
               st_n   = S_IDLE;
               tens_n = 4'd0;
               ones_n = 4'd0;
               cnt_n  = 2'd0;
            end else if (do_start) begin
               st_n   = S_ENTRY;
               tens_n = 4'd0;
               ones_n = 4'd0;
               cnt_n  = 2'd0;
               pre_n  = '0;
            end
         end
         default: st_n = S_IDLE;
      endcase
`ifdef AUTO_TIMEOUT_EN
      if (st != S_ENTRY) begin
         to_n = '0;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st   <= S_IDLE;
         tens <= 4'd0;
         ones <= 4'd0;
         cnt  <= 2'd0;
         rem  <= 16'd0;
         pre  <= '0;
`ifdef AUTO_TIMEOUT_EN
         to_cnt <= '0;
`endif
      end else begin
         st   <= st_n;
         tens <= tens_n;
         ones <= ones_n;
         cnt  <= cnt_n;
         rem  <= rem_n;
         pre  <= pre_n;
`ifdef AUTO_TIMEOUT_EN
         to_cnt <= to_n;
`endif
      end
   end

   assign bus.state    = st;
   assign bus.amt_tens = tens;
   assign bus.amt_ones = ones;
   assign bus.rem_sec  = rem;
   assign bus.charging = (st == S_CHARGE);
   assign bus.done     = (st == S_DONE);

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Bench for charge_session_ctrl: per-cycle check against a session-level model plus literal checkpoints.
module tb_charge_session_ctrl;

   localparam int TICK_DIV   = 20;
   localparam int SPU        = 2;
   localparam int TB_TIMEOUT = 8;

   localparam int K_NONE  = 0;
   localparam int K_CLEAR = 1;
   localparam int K_ENTER = 2;
   localparam int K_START = 3;
   localparam int K_DIGIT = 4;

   logic CLK   = 1'b0;
   logic RST_N = 1'b1;

   charge_session_ctrl_if bus ();

   charge_session_ctrl #(
      .TICK_DIV     (TICK_DIV),
      .SEC_PER_UNIT (SPU)
`ifdef AUTO_TIMEOUT_EN
      , .IDLE_TIMEOUT (TB_TIMEOUT)
`endif
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int at;
      bit clr;
      bit ent;
      bit sta;
      int num;
   } key_ev_t;

   key_ev_t    key_q[$];
   key_ev_t    ev;
   int         cyc = 0;
   logic [1:0] m_state = 2'd0;
   logic [3:0] m_tens = 4'd0;
   logic [3:0] m_ones = 4'd0;
   int         m_cnt = 0;
   int         m_rem = 0;
   int         m_r0 = 0;
   int         m_t0 = 0;
   int         m_last = 0;
   bit         kv_prev = 1'b0;
   bit         has_key;
   bit         timed_out;
   int         kind;
   int         n_compared = 0;
   int         n_mismatched = 0;
   logic [27:0] act_v, exp_v;

   // Session model: a key acts on the 4th edge after its rise is sampled; the countdown is elapsed/TICK_DIV
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_state = 2'd0; m_tens = 4'd0; m_ones = 4'd0; m_cnt = 0;
         m_rem = 0; m_r0 = 0; m_t0 = 0; m_last = 0;
         kv_prev = 1'b0;
         key_q.delete();
      end else begin
         cyc++;
         if (bus.key_valid && !kv_prev) begin
            ev.at = cyc + 3; ev.clr = bus.key_clear; ev.ent = bus.key_enter;
            ev.sta = bus.key_start; ev.num = int'(bus.key_num);
            key_q.push_back(ev);
         end
         kv_prev = bus.key_valid;
         has_key = 1'b0;
         kind = K_NONE;
         if (key_q.size() > 0 && key_q[0].at == cyc) begin
            ev = key_q.pop_front();
            has_key = 1'b1;
            if (ev.clr) kind = K_CLEAR;
            else if (ev.ent) kind = K_ENTER;
            else if (ev.sta) kind = K_START;
            else if (ev.num <= 9) kind = K_DIGIT;
         end
         case (m_state)
            2'd0: if (kind == K_START) begin
               m_state = 2'd1; m_tens = 4'd0; m_ones = 4'd0; m_cnt = 0; m_last = cyc;
            end
            2'd1: begin
               timed_out = 1'b0;
`ifdef AUTO_TIMEOUT_EN
               if (!has_key && (cyc - m_last) == TB_TIMEOUT * TICK_DIV) timed_out = 1'b1;
`endif
               if (has_key) m_last = cyc;
               if (timed_out) begin
                  m_state = 2'd0; m_tens = 4'd0; m_ones = 4'd0; m_cnt = 0;
               end else if (kind == K_CLEAR) begin
                  m_tens = 4'd0; m_ones = 4'd0; m_cnt = 0;
               end else if (kind == K_ENTER && (m_tens * 10 + m_ones) != 0) begin
                  m_r0 = (m_tens * 10 + m_ones) * SPU; m_t0 = cyc; m_state = 2'd2;
               end else if (kind == K_DIGIT && m_cnt < 2) begin
                  m_tens = m_ones; m_ones = 4'(ev.num); m_cnt++;
               end
            end
            2'd2: begin
               if (kind == K_CLEAR) begin
                  m_state = 2'd0; m_tens = 4'd0; m_ones = 4'd0; m_cnt = 0;
               end else if (cyc - m_t0 == m_r0 * TICK_DIV) begin
                  m_state = 2'd3;
               end
            end
            default: begin
               if (kind == K_CLEAR) begin
                  m_state = 2'd0; m_tens = 4'd0; m_ones = 4'd0; m_cnt = 0;
               end else if (kind == K_START) begin
                  m_state = 2'd1; m_tens = 4'd0; m_ones = 4'd0; m_cnt = 0; m_last = cyc;
               end
            end
         endcase
         m_rem = (m_state == 2'd2) ? m_r0 - (cyc - m_t0) / TICK_DIV : 0;
      end
   end

   always @(negedge CLK) begin
      act_v = {bus.state, bus.amt_tens, bus.amt_ones, bus.rem_sec, bus.charging, bus.done};
      exp_v = {m_state, m_tens, m_ones, 16'(m_rem), m_state == 2'd2, m_state == 2'd3};
      n_compared++;
      if (act_v !== exp_v) begin
         n_mismatched++;
         $display("[TB] FAIL cycle_model cyc=%0d actual st=%0d amt=%0d%0d rem=%0d chg=%0b done=%0b required st=%0d amt=%0d%0d rem=%0d chg=%0b done=%0b",
                  cyc, bus.state, bus.amt_tens, bus.amt_ones, bus.rem_sec, bus.charging, bus.done,
                  m_state, m_tens, m_ones, m_rem, m_state == 2'd2, m_state == 2'd3);
      end
   end

   task automatic check_output(input string name, input int actual, input int expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic drive_key(input bit clr, input bit ent, input bit sta, input int num);
      bus.key_clear = clr;
      bus.key_enter = ent;
      bus.key_start = sta;
      bus.key_num   = 5'(num);
      bus.key_valid = 1'b1;
   endtask

   task automatic release_key();
      bus.key_valid = 1'b0;
      bus.key_clear = 1'b0;
      bus.key_enter = 1'b0;
      bus.key_start = 1'b0;
      bus.key_num   = 5'd20;
      repeat (3) @(negedge CLK);
   endtask

   task automatic apply_stimulus(input bit clr, input bit ent, input bit sta, input int num, input int hold);
      @(negedge CLK);
      drive_key(clr, ent, sta, num);
      repeat (hold) @(negedge CLK);
      release_key();
   endtask

   task automatic press(input bit clr, input bit ent, input bit sta, input int num);
      apply_stimulus(clr, ent, sta, num, 6);
   endtask

   task automatic wait_until_cycle(input int target);
      int budget = 5000;
      while (cyc < target && budget > 0) begin
         @(negedge CLK);
         budget--;
      end
      check_output("wait_cycle", cyc, target);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int fin;
      bus.key_valid = 1'b0; bus.key_clear = 1'b0; bus.key_enter = 1'b0;
      bus.key_start = 1'b0; bus.key_num = 5'd20;
      #1 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check_output("reset_state", int'(bus.state), 0);
      check_output("reset_rem", int'(bus.rem_sec), 0);
      check_output("reset_charging", int'(bus.charging), 0);
      check_output("reset_done", int'(bus.done), 0);
      check_output("reset_amt", int'({bus.amt_tens, bus.amt_ones}), 0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      press(0, 0, 1, 20);
      check_output("start_to_entry", int'(bus.state), 1);
      press(0, 0, 0, 2);
      press(0, 0, 0, 5);
      check_output("amt_tens_25", int'(bus.amt_tens), 2);
      check_output("amt_ones_25", int'(bus.amt_ones), 5);
      press(0, 1, 0, 20);
      check_output("enter_to_charge", int'(bus.state), 2);
      check_output("rem_50", int'(bus.rem_sec), 50);
      check_output("charging_on", int'(bus.charging), 1);

      fin = m_t0 + 50 * TICK_DIV;
      wait_until_cycle(fin - 1);
      check_output("rem_last_second", int'(bus.rem_sec), 1);
      check_output("still_charging", int'(bus.state), 2);
      wait_until_cycle(fin);
      check_output("done_state", int'(bus.state), 3);
      check_output("done_flag", int'(bus.done), 1);
      check_output("done_charging_off", int'(bus.charging), 0);
      check_output("done_amt_held", int'(bus.amt_ones), 5);

      press(0, 0, 1, 20);
      check_output("done_start_entry", int'(bus.state), 1);
      press(0, 0, 0, 1);
      press(0, 0, 0, 2);
      press(0, 0, 0, 3);
      press(0, 0, 0, 20);
      check_output("third_digit_tens", int'(bus.amt_tens), 1);
      check_output("third_digit_ones", int'(bus.amt_ones), 2);
      press(1, 0, 0, 20);
      check_output("clear_amt", int'({bus.amt_tens, bus.amt_ones}), 0);
      press(0, 1, 0, 20);
      check_output("enter_zero_state", int'(bus.state), 1);
      check_output("enter_zero_charging", int'(bus.charging), 0);

      press(0, 0, 0, 0);
      press(0, 0, 0, 5);
      press(0, 0, 1, 9);
      check_output("start_beats_digit", int'({bus.amt_tens, bus.amt_ones}), 5);
      press(0, 1, 0, 20);
      check_output("rem_10", int'(bus.rem_sec), 10);

      @(negedge CLK);
      drive_key(1, 0, 0, 20);
      repeat (4) @(negedge CLK);
      check_output("abort_state", int'(bus.state), 0);
      check_output("abort_charging", int'(bus.charging), 0);
      check_output("abort_rem", int'(bus.rem_sec), 0);
      release_key();

      press(0, 0, 1, 20);
      apply_stimulus(0, 0, 0, 7, 100);
      check_output("held_key_single_event", int'({bus.amt_tens, bus.amt_ones}), 7);
      press(1, 0, 0, 20);

      press(0, 0, 0, 1);
      press(0, 1, 0, 20);
      fin = m_t0 + 2 * TICK_DIV;
      wait_until_cycle(fin - 4);
      drive_key(1, 0, 0, 20);
      wait_until_cycle(fin);
      check_output("clear_on_final_tick", int'(bus.state), 0);
      release_key();

      press(0, 0, 1, 20);
      press(0, 0, 0, 1);
      press(0, 1, 0, 20);
      fin = m_t0 + 2 * TICK_DIV;
      wait_until_cycle(fin - 4);
      drive_key(0, 1, 0, 20);
      wait_until_cycle(fin);
      check_output("enter_on_final_tick", int'(bus.state), 3);
      release_key();

      press(0, 0, 1, 20);
      repeat (TB_TIMEOUT * TICK_DIV + 5) @(negedge CLK);
`ifdef AUTO_TIMEOUT_EN
      check_output("entry_timeout", int'(bus.state), 0);
`else
      check_output("entry_no_timeout", int'(bus.state), 1);
`endif

      press(0, 0, 1, 20);
      press(0, 0, 0, 3);
      press(0, 1, 0, 20);
      check_output("rem_6", int'(bus.rem_sec), 6);
      #2 RST_N = 1'b0;
      #1;
      check_output("async_reset_charging", int'(bus.charging), 0);
      check_output("async_reset_state", int'(bus.state), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      check_output("no_resume_state", int'(bus.state), 0);
      check_output("no_resume_rem", int'(bus.rem_sec), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
